// File: rtl/ifetch_pc_unit_pkg.sv
// rtl/ifetch_pc_unit_pkg.sv - shared encodings for the fetch/PC stage and decoder
package ifetch_pc_unit_pkg;

  // Fetch-stage FSM states
  localparam logic [1:0] S_RUN   = 2'b00;
  localparam logic [1:0] S_HALT  = 2'b01;
  localparam logic [1:0] S_FAULT = 2'b10;

  // Fault cause codes reported on fault_cause
  localparam logic [1:0] FC_NONE     = 2'b00;
  localparam logic [1:0] FC_MISALIGN = 2'b01;
  localparam logic [1:0] FC_RANGE    = 2'b10;

  // Opcode/funct values shared with the decoder
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] FUNCT_JR = 6'h08;

  // Decoder flow-control bundle as seen by next-PC selection
  typedef struct packed {
    logic branch;
    logic nbranch;
    logic jmp;
    logic jal;
    logic jr;
  } npc_ctrl_t;

  // Pseudo-direct jump target: upper nibble of PC+4, index, word offset
  function automatic logic [31:0] jump_target(input logic [31:0] pc_plus_4,
                                              input logic [25:0] index);
    return {pc_plus_4[31:28], index, 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_pc_unit_if.sv
// rtl/ifetch_pc_unit_if.sv - fetch-stage control/status bundle
interface ifetch_pc_unit_if;
  logic [31:0] Addr_Result;
  logic        Zero;
  logic [31:0] Read_data_1;
  logic [25:0] Jump_index;
  logic        Branch;
  logic        nBranch;
  logic        Jmp;
  logic        Jal;
  logic        Jr;
  logic        Stall;
  logic        Halt_req;
  logic        Resume;
  logic [31:0] PC;
  logic [31:0] PC_plus_4;
  logic [31:0] link_addr;
  logic        running;
  logic        fault;
  logic [1:0]  fault_cause;
  logic [31:0] fault_pc;
  logic [31:0] retired_cnt;

  // Core side: drives controls, observes PC and status
  modport master (
    output Addr_Result, Zero, Read_data_1, Jump_index, Branch, nBranch,
           Jmp, Jal, Jr, Stall, Halt_req, Resume,
    input  PC, PC_plus_4, link_addr, running, fault, fault_cause,
           fault_pc, retired_cnt
  );

  // PC unit side
  modport slave (
    input  Addr_Result, Zero, Read_data_1, Jump_index, Branch, nBranch,
           Jmp, Jal, Jr, Stall, Halt_req, Resume,
    output PC, PC_plus_4, link_addr, running, fault, fault_cause,
           fault_pc, retired_cnt
  );
endinterface

// File: rtl/ifetch_pc_unit_npc_select.sv
// rtl/ifetch_pc_unit_npc_select.sv - candidate next PC and its fault classification
module ifetch_pc_unit_npc_select
  import ifetch_pc_unit_pkg::*;
#(
  parameter int unsigned IMEM_WORDS = 16384
) (
  input  logic [31:0] PC_plus_4,
  input  npc_ctrl_t   ctrl,
  input  logic        Zero,
  input  logic [31:0] Addr_Result,
  input  logic [31:0] Read_data_1,
  input  logic [25:0] Jump_index,
  output logic [31:0] next_pc,
  output logic [1:0]  fault_cause
);

  // One bit wider so a 4 GiB memory size cannot wrap the limit to zero
  localparam logic [32:0] IMEM_BYTES = 33'(IMEM_WORDS) * 33'd4;

  logic taken;

  assign taken = (ctrl.branch & Zero) | (ctrl.nbranch & ~Zero);

  // Priority: jr, then j/jal, then taken branch, else fall through
  always_comb begin
    next_pc = PC_plus_4;
    if (ctrl.jr)
      next_pc = Read_data_1;
    else if (ctrl.jmp | ctrl.jal)
      next_pc = jump_target(PC_plus_4, Jump_index);
    else if (taken)
      next_pc = Addr_Result;
  end

  // Misalignment is reported ahead of range so a bad jr shows the root cause
  always_comb begin
    fault_cause = FC_NONE;
    if (next_pc[1:0] != 2'b00)
      fault_cause = FC_MISALIGN;
    else if ({1'b0, next_pc} >= IMEM_BYTES)
      fault_cause = FC_RANGE;
  end

endmodule

// File: rtl/ifetch_pc_unit.sv
// rtl/ifetch_pc_unit.sv - PC register, run/halt/fault FSM and retire counter
module ifetch_pc_unit
  import ifetch_pc_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 16384
) (
  input  logic                clock,
  input  logic                reset,
  ifetch_pc_unit_if.slave     bus
);

  logic [1:0]  state;
  logic [31:0] pc;
  logic [31:0] link_q;
  logic [31:0] cnt_q;
  logic [31:0] fault_pc_q;
  logic [1:0]  fault_cause_q;
  logic [31:0] pc_plus_4;
  logic [31:0] next_pc;
  logic [1:0]  cand_cause;
  npc_ctrl_t   ctrl;

  assign pc_plus_4 = pc + 32'd4;
  assign ctrl      = '{branch:  bus.Branch,  nbranch: bus.nBranch,
                       jmp:     bus.Jmp,     jal:     bus.Jal,
                       jr:      bus.Jr};

  ifetch_pc_unit_npc_select #(
    .IMEM_WORDS (IMEM_WORDS)
  ) u_npc (
    .PC_plus_4   (pc_plus_4),
    .ctrl        (ctrl),
    .Zero        (bus.Zero),
    .Addr_Result (bus.Addr_Result),
    .Read_data_1 (bus.Read_data_1),
    .Jump_index  (bus.Jump_index),
    .next_pc     (next_pc),
    .fault_cause (cand_cause)
  );

  // FSM and architectural registers; a fault blocks commit and freezes PC
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= S_RUN;
      pc            <= RESET_PC;
      link_q        <= 32'd0;
      cnt_q         <= 32'd0;
      fault_pc_q    <= 32'd0;
      fault_cause_q <= FC_NONE;
    end else begin
      case (state)
        S_RUN: begin
          if (bus.Stall) begin
            if (bus.Halt_req)
              state <= S_HALT;
          end else if (cand_cause != FC_NONE) begin
            state         <= S_FAULT;
            fault_cause_q <= cand_cause;
            fault_pc_q    <= pc;
          end else begin
            pc    <= next_pc;
            cnt_q <= cnt_q + 32'd1;
            if (bus.Jal)
              link_q <= pc_plus_4;
            if (bus.Halt_req)
              state <= S_HALT;
          end
        end
        S_HALT: begin
          if (bus.Resume)
            state <= S_RUN;
        end
        default: begin
          state <= S_FAULT;
        end
      endcase
    end
  end

  assign bus.PC          = pc;
  assign bus.PC_plus_4   = pc_plus_4;
  assign bus.link_addr   = link_q;
  assign bus.running     = (state == S_RUN);
  assign bus.fault       = (state == S_FAULT);
  assign bus.fault_cause = fault_cause_q;
  assign bus.fault_pc    = fault_pc_q;
  assign bus.retired_cnt = cnt_q;

endmodule

// File: tb/tb_ifetch_pc_unit.sv
// tb/tb_ifetch_pc_unit.sv - scoreboard bench with reference model for ifetch_pc_unit
module tb_ifetch_pc_unit;

  localparam int unsigned LIMIT = 16384 * 4;

  typedef struct {
    bit        rst;
    bit [31:0] addr;
    bit        zero;
    bit [31:0] rd1;
    bit [25:0] ji;
    bit        br, nbr, jmp, jal, jr, stall, halt, resume;
  } stim_t;

  typedef struct {
    bit [31:0] pc, link, cnt, fpc;
    bit [1:0]  cause;
    bit        running, fault;
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  // Reference model state: 0 = run, 1 = halted, 2 = faulted
  int        m_mode;
  bit [31:0] m_pc, m_link, m_cnt, m_fpc;
  bit [1:0]  m_cause;

  ifetch_pc_unit_if bus();

  ifetch_pc_unit dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  function automatic stim_t plain();
    stim_t s;
    s = '{rst: 0, addr: 0, zero: 0, rd1: 0, ji: 0, br: 0, nbr: 0, jmp: 0,
          jal: 0, jr: 0, stall: 0, halt: 0, resume: 0};
    return s;
  endfunction

  // Advance the model by one clock edge for the given stimulus
  task automatic predict(input stim_t s);
    bit [31:0] tgt;
    bit        taken;
    exp_t      e;
    if (s.rst) begin
      m_mode = 0; m_pc = 0; m_link = 0; m_cnt = 0; m_fpc = 0; m_cause = 0;
    end else if (m_mode == 0) begin
      if (s.stall) begin
        if (s.halt) m_mode = 1;
      end else begin
        taken = (s.br && s.zero) || (s.nbr && !s.zero);
        if (s.jr)                 tgt = s.rd1;
        else if (s.jmp || s.jal)  tgt = ((m_pc + 4) & 32'hF000_0000) + s.ji * 4;
        else if (taken)           tgt = s.addr;
        else                      tgt = m_pc + 4;
        if (tgt % 4 != 0) begin
          m_mode = 2; m_cause = 1; m_fpc = m_pc;
        end else if (tgt >= LIMIT) begin
          m_mode = 2; m_cause = 2; m_fpc = m_pc;
        end else begin
          if (s.jal) m_link = m_pc + 4;
          m_pc  = tgt;
          m_cnt = m_cnt + 1;
          if (s.halt) m_mode = 1;
        end
      end
    end else if (m_mode == 1) begin
      if (s.resume) m_mode = 0;
    end
    e.pc = m_pc; e.link = m_link; e.cnt = m_cnt; e.fpc = m_fpc;
    e.cause = m_cause; e.running = (m_mode == 0); e.fault = (m_mode == 2);
    exp_q.push_back(e);
  endtask

  // Drive one cycle of stimulus (called just after a falling edge)
  task automatic step(input stim_t s);
    reset           = s.rst;
    bus.Addr_Result = s.addr;
    bus.Zero        = s.zero;
    bus.Read_data_1 = s.rd1;
    bus.Jump_index  = s.ji;
    bus.Branch      = s.br;
    bus.nBranch     = s.nbr;
    bus.Jmp         = s.jmp;
    bus.Jal         = s.jal;
    bus.Jr          = s.jr;
    bus.Stall       = s.stall;
    bus.Halt_req    = s.halt;
    bus.Resume      = s.resume;
    predict(s);
    @(negedge clock);
  endtask

  function automatic stim_t rand_stim();
    stim_t s;
    s = plain();
    s.zero = 1'($urandom);
    s.addr = ($urandom_range(0, 15) == 0) ? $urandom : {16'd0, 14'($urandom_range(0, 16383)), 2'b00};
    s.rd1  = ($urandom_range(0, 15) == 0) ? $urandom : {16'd0, 14'($urandom_range(0, 16383)), 2'b00};
    s.ji   = ($urandom_range(0, 15) == 0) ? 26'($urandom) : 26'($urandom_range(0, 16383));
    case ($urandom_range(0, 5))
      1: s.br  = 1;
      2: s.nbr = 1;
      3: s.jmp = 1;
      4: s.jal = 1;
      5: s.jr  = 1;
      default: ;
    endcase
    if ($urandom_range(0, 7) == 0) begin
      s.br = 1'($urandom); s.nbr = 1'($urandom); s.jal = 1'($urandom); s.jr = 1'($urandom);
    end
    s.stall  = ($urandom_range(0, 3) == 0);
    s.halt   = ($urandom_range(0, 15) == 0);
    s.resume = ($urandom_range(0, 2) == 0);
    s.rst    = (m_mode == 2) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 99) == 0);
    return s;
  endfunction

  task automatic chk(input string name, input bit [31:0] act, input bit [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: after each rising edge, compare DUT outputs with the oldest prediction
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("pc",          bus.PC,                 e.pc);
        chk("pc_plus_4",   bus.PC_plus_4,          e.pc + 32'd4);
        chk("link_addr",   bus.link_addr,          e.link);
        chk("retired_cnt", bus.retired_cnt,        e.cnt);
        chk("running",     32'(bus.running),       32'(e.running));
        chk("fault",       32'(bus.fault),         32'(e.fault));
        chk("fault_cause", 32'(bus.fault_cause),   32'(e.cause));
        chk("fault_pc",    bus.fault_pc,           e.fpc);
      end
    end
  end

  initial begin
    stim_t s;
    m_mode = 0; m_pc = 0; m_link = 0; m_cnt = 0; m_fpc = 0; m_cause = 0;

    s = plain(); s.rst = 1;
    step(s);
    step(s);
    repeat (3) step(plain());
    s = plain(); s.br = 1; s.zero = 1; s.addr = 32'h40;
    step(s);
    s = plain(); s.nbr = 1; s.zero = 1; s.addr = 32'h80;
    step(s);
    s = plain(); s.nbr = 1; s.zero = 0; s.addr = 32'h44;
    step(s);
    s = plain(); s.jal = 1; s.ji = 26'h10;
    step(s);
    s = plain(); s.jr = 1; s.rd1 = 32'h48;
    step(s);
    s = plain(); s.stall = 1; s.jr = 1; s.rd1 = 32'h3;
    repeat (3) step(s);
    step(plain());
    s = plain(); s.halt = 1;
    step(s);
    repeat (5) begin
      s = rand_stim(); s.rst = 0; s.resume = 0;
      step(s);
    end
    s = plain(); s.resume = 1; s.halt = 1;
    step(s);
    step(plain());
    s = plain(); s.jr = 1; s.rd1 = 32'h102;
    step(s);
    repeat (4) begin
      s = rand_stim(); s.rst = 0;
      step(s);
    end
    s = plain(); s.rst = 1;
    step(s);
    step(plain());
    s = plain(); s.stall = 1; s.halt = 1;
    step(s);
    s = plain(); s.resume = 1;
    step(s);
    s = plain(); s.jr = 1; s.rd1 = 32'h10000;
    step(s);
    step(plain());
    s = plain(); s.rst = 1;
    step(s);
    s = plain(); s.jr = 1; s.rd1 = 32'hFFFC;
    step(s);

    repeat (1500) step(rand_stim());

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clock);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d predictions left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
